// File: rtl/entrada_pkg.sv
// Shared constants and FSM state encoding for the operator-input (IN instruction) front end.
package entrada_pkg;

   localparam int unsigned WordW         = 32;
   localparam int unsigned DefDebCycles  = 500000;
   localparam int unsigned DefSyncStages = 2;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StWaitPress,
      StWaitRelease,
      StDone
   } state_e;

endpackage

// File: rtl/botao_debounce.sv
// Synchroniser and counter debouncer for the active-low enter key.
// Emits one-cycle press/release pulses when the debounced state flips.
module botao_debounce
   import entrada_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DefDebCycles,
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic clock,
   input  logic reset,
   input  logic enter,
   output logic pressed,
   output logic press_p,
   output logic release_p
);

   localparam int unsigned     CntW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CntW-1:0]        cnt_q;
   logic                   stable_q;
   logic                   key;

   // Synchroniser resets to the released level so a held key reads as a fresh press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= enter;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign key = ~sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         press_p   <= 1'b0;
         release_p <= 1'b0;
      end else begin
         press_p   <= 1'b0;
         release_p <= 1'b0;
         if (key == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntMax) begin
            stable_q  <= key;
            cnt_q     <= '0;
            press_p   <= key;
            release_p <= ~key;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign pressed = stable_q;

endmodule

// File: rtl/entrada_handshake.sv
// IN-instruction handshake: waits for a clean press/release, latches the switch word, raises sinal.
// Define ENTRADA_SINAL_EN to treat the top switch as a sign flag over a magnitude.
module entrada_handshake
   import entrada_pkg::*;
#(
   parameter int unsigned DATA_W      = 18,
   parameter int unsigned DEB_CYCLES  = DefDebCycles,
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] entrada,
   input  logic              enter,
   input  logic              in_req,
   output logic              sinal,
   output logic [WordW-1:0]  valor,
   output logic              aguardando
);

   logic [DATA_W-1:0] ent_q [SYNC_STAGES];
   logic [DATA_W-1:0] ent_sync;
   logic [WordW-1:0]  ext_val;
   logic              pressed;
   logic              press_p;
   logic              release_p;
   state_e            state_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         ent_q[0] <= entrada;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ent_q[i] <= ent_q[i-1];
         end
      end
   end

   assign ent_sync = ent_q[SYNC_STAGES-1];

`ifdef ENTRADA_SINAL_EN
   logic [WordW-1:0] mag;
   assign mag     = WordW'(ent_sync[DATA_W-2:0]);
   assign ext_val = ent_sync[DATA_W-1] ? (~mag + WordW'(1)) : mag;
`else
   assign ext_val = WordW'(ent_sync);
`endif

   botao_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_debounce (
      .clock     (clock),
      .reset     (reset),
      .enter     (enter),
      .pressed   (pressed),
      .press_p   (press_p),
      .release_p (release_p)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         sinal      <= 1'b0;
         valor      <= '0;
         aguardando <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_req) state_q <= StArm;
            end
            // A key still held from before the request must be released first.
            StArm: begin
               if (!in_req) begin
                  state_q <= StIdle;
               end else if (!pressed) begin
                  state_q    <= StWaitPress;
                  aguardando <= 1'b1;
               end
            end
            StWaitPress: begin
               if (!in_req) begin
                  state_q    <= StIdle;
                  aguardando <= 1'b0;
               end else if (press_p) begin
                  valor   <= ext_val;
                  state_q <= StWaitRelease;
               end
            end
            StWaitRelease: begin
               if (!in_req) begin
                  state_q    <= StIdle;
                  aguardando <= 1'b0;
               end else if (release_p) begin
                  state_q    <= StDone;
                  aguardando <= 1'b0;
                  sinal      <= 1'b1;
               end
            end
            StDone: begin
               if (!in_req) begin
                  state_q <= StIdle;
                  sinal   <= 1'b0;
               end
            end
            default: begin
               state_q    <= StIdle;
               sinal      <= 1'b0;
               aguardando <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_entrada_handshake.sv
// Directed plus randomized bench for entrada_handshake (DEB_CYCLES=4, SYNC_STAGES=2).
// Expected words follow ENTRADA_SINAL_EN the same way the design build does.
module tb_entrada_handshake;

   localparam int unsigned DW      = 18;
   localparam int          RiseLat = 7; // 2 sync + 4 debounce samples + 1 FSM register

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] entrada;
   logic          enter;
   logic          in_req;
   logic          sinal;
   logic [31:0]   valor;
   logic          aguardando;

   int            tests = 0;
   int            fails = 0;
   logic [31:0]   exp_valor;
   int            lat;

   always #5 clock = ~clock;

   entrada_handshake #(
      .DATA_W      (DW),
      .DEB_CYCLES  (4),
      .SYNC_STAGES (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .entrada    (entrada),
      .enter      (enter),
      .in_req     (in_req),
      .sinal      (sinal),
      .valor      (valor),
      .aguardando (aguardando)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Reference extension computed with plain integer arithmetic.
   function automatic logic [31:0] ref_ext(input logic [DW-1:0] w);
`ifdef ENTRADA_SINAL_EN
      int m;
      m = int'(w) % (1 << (DW - 1));
      if (int'(w) >= (1 << (DW - 1))) m = -m;
      return 32'(m);
`else
      return 32'(int'(w));
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_sinal(input int max, output int n);
      n = 0;
      while (sinal !== 1'b1 && n < max) begin
         tick(1);
         n++;
      end
   endtask

   task automatic press_release(input logic [DW-1:0] v, input int hold, output int n);
      entrada = v;
      enter   = 1'b0;
      tick(hold);
      enter = 1'b1;
      wait_sinal(20, n);
   endtask

   initial begin
      reset   = 1'b1;
      in_req  = 1'b0;
      enter   = 1'b1;
      entrada = '0;
      tick(2);
      check("rst_sinal", 32'(sinal), 32'd0);
      check("rst_valor", valor, 32'd0);
      check("rst_aguard", 32'(aguardando), 32'd0);
      reset = 1'b0;
      tick(2);

      // Clean IN
      in_req = 1'b1;
      tick(3);
      check("clean_aguard", 32'(aguardando), 32'd1);
      press_release(18'h00005, 10, lat);
      exp_valor = 32'h5;
      check("clean_lat", 32'(lat), 32'(RiseLat));
      check("clean_valor", valor, exp_valor);
      check("clean_aguard_off", 32'(aguardando), 32'd0);
      tick(3);
      check("clean_hold", 32'(sinal), 32'd1);
      in_req = 1'b0;
      check("clean_before_fall", 32'(sinal), 32'd1);
      tick(1);
      check("clean_fall", 32'(sinal), 32'd0);

      // Bounce: 2-clk runs never debounce, then settle pressed
      in_req = 1'b1;
      tick(3);
      entrada = 18'h0ABCD;
      for (int i = 0; i < 10; i++) begin
         enter = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      enter = 1'b0;
      tick(12);
      exp_valor = ref_ext(18'h0ABCD);
      check("bounce_valor", valor, exp_valor);
      check("bounce_wait_rel", 32'(aguardando), 32'd1);
      check("bounce_no_sinal", 32'(sinal), 32'd0);
      entrada = 18'h3FFFF;
      tick(4);
      enter = 1'b1;
      wait_sinal(20, lat);
      check("bounce_lat", 32'(lat), 32'(RiseLat));
      check("held_change_ignored", valor, exp_valor);
      in_req = 1'b0;
      tick(2);

      // Short glitch and a full press without a request are both discarded
      entrada = 18'h11111;
      enter   = 1'b0;
      tick(3);
      enter = 1'b1;
      tick(10);
      check("glitch_sinal", 32'(sinal), 32'd0);
      check("glitch_aguard", 32'(aguardando), 32'd0);
      enter = 1'b0;
      tick(10);
      enter = 1'b1;
      tick(10);
      check("noreq_valor", valor, exp_valor);
      check("noreq_sinal", 32'(sinal), 32'd0);

      // Abort in WAIT_PRESS
      in_req = 1'b1;
      tick(3);
      check("abort_aguard_on", 32'(aguardando), 32'd1);
      entrada = 18'h00777;
      in_req  = 1'b0;
      tick(2);
      check("abort_aguard_off", 32'(aguardando), 32'd0);
      enter = 1'b0;
      tick(10);
      enter = 1'b1;
      tick(10);
      check("abort_valor", valor, exp_valor);
      check("abort_sinal", 32'(sinal), 32'd0);

      // Sign/extension word, then reset in WAIT_RELEASE with the key held
      in_req = 1'b1;
      tick(3);
      entrada = 18'h20007;
      enter   = 1'b0;
      tick(10);
`ifdef ENTRADA_SINAL_EN
      check("ext_20007", valor, 32'hFFFF_FFF9);
`else
      check("ext_20007", valor, 32'h0002_0007);
`endif
      check("ext_wait_rel", 32'(aguardando), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_sinal", 32'(sinal), 32'd0);
      check("mid_rst_valor", valor, 32'd0);
      check("mid_rst_aguard", 32'(aguardando), 32'd0);
      exp_valor = 32'd0;
      in_req    = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(10);
      in_req = 1'b1;
      tick(10);
      check("held_arm_aguard", 32'(aguardando), 32'd0);
      check("held_arm_valor", valor, exp_valor);
      check("held_arm_sinal", 32'(sinal), 32'd0);
      enter = 1'b1;
      tick(10);
      check("held_released", 32'(aguardando), 32'd1);
      press_release(18'h00042, 10, lat);
      exp_valor = ref_ext(18'h00042);
      check("held_lat", 32'(lat), 32'(RiseLat));
      check("held_valor", valor, exp_valor);
      in_req = 1'b0;
      tick(2);

      // Randomized requests, some aborted
      for (int it = 0; it < 10; it++) begin
         logic [DW-1:0] v;
         v      = DW'($urandom);
         in_req = 1'b1;
         tick(int'($urandom_range(2, 5)));
         if ($urandom_range(0, 3) == 0) begin
            in_req  = 1'b0;
            entrada = v;
            tick(2);
            enter = 1'b0;
            tick(10);
            enter = 1'b1;
            tick(10);
            check("rnd_abort_valor", valor, exp_valor);
            check("rnd_abort_sinal", 32'(sinal), 32'd0);
         end else begin
            press_release(v, int'($urandom_range(8, 15)), lat);
            exp_valor = ref_ext(v);
            check("rnd_lat", 32'(lat), 32'(RiseLat));
            check("rnd_valor", valor, exp_valor);
            in_req = 1'b0;
            tick(1);
            check("rnd_fall", 32'(sinal), 32'd0);
         end
         tick(int'($urandom_range(1, 4)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
